// File: rtl/mem_stream_reader_pkg.sv
// Shared types and helpers for the RAM stream reader and its output buffer.
`default_nettype none

package mem_stream_reader_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Inclusive range length, wrapping through the top of the address space.
  function automatic logic [31:0] calc_len(input logic [31:0] s,
                                           input logic [31:0] e,
                                           input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return ((e - s) & mask) + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stream_reader_stream_fifo2.sv
// stream_fifo2: two-entry valid/ready buffer; simultaneous push and pop keep occupancy.
`default_nettype none

module stream_fifo2
  import mem_stream_reader_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         pop;

  assign pop       = (count_q != 2'd0) & out_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign occupancy = count_q;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data;
        else                 tail_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: walks an inclusive RAM address range and streams {addr,data} beats.
`default_nettype none

module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);

  localparam logic [2:0] DEPTH3 = 3'(BUF_DEPTH);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   inflight_addr_q, inflight_addr_d;

  logic [1:0]          occ;
  logic                fifo_pop;
  logic [2:0]          pending;
  logic                issue;

  assign ram_wren = 1'b0;
  assign ram_data = '0;
  assign busy     = busy_q;
  assign done     = done_q;

  // A beat leaving this cycle frees its slot in time for the new read's result.
  assign fifo_pop = out_valid & out_ready;
  assign pending  = 3'(occ) + 3'(inflight_q) - 3'(fifo_pop);
  assign issue    = (state_q == ST_RUN) && (issue_cnt_q != '0) && (pending < DEPTH3);

  // The RAM registers the address on the edge, so it is presented combinationally.
  assign ram_address = issue ? cur_addr_q : last_addr_q;

  stream_fifo2 #(
    .W(ADDR_W + DATA_W)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (inflight_q),
    .push_data ({inflight_addr_q, ram_q}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_addr, out_data}),
    .occupancy (occ)
  );

  always_comb begin
    state_d         = state_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    cur_addr_d      = cur_addr_q;
    last_addr_d     = last_addr_q;
    issue_cnt_d     = issue_cnt_q;
    inflight_d      = 1'b0;
    inflight_addr_d = inflight_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d  = start_addr;
          issue_cnt_d = (ADDR_W+1)'(calc_len(32'(start_addr), 32'(end_addr), ADDR_W));
          busy_d      = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          inflight_d      = 1'b1;
          inflight_addr_d = cur_addr_q;
          last_addr_d     = cur_addr_q;
          cur_addr_d      = cur_addr_q + ADDR_W'(1);
          issue_cnt_d     = issue_cnt_q - (ADDR_W+1)'(1);
        end
        if ((issue_cnt_q == '0) && !inflight_q && (occ == 2'd1) && fifo_pop) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      cur_addr_q      <= '0;
      last_addr_q     <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      cur_addr_q      <= cur_addr_d;
      last_addr_q     <= last_addr_d;
      issue_cnt_q     <= issue_cnt_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader with a behavioural synchronous RAM.
`default_nettype none

module tb_mem_stream_reader;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } beat_t;

  typedef struct {
    logic [7:0] s;
    logic [7:0] e;
    int         mode;
    int         poke;
    int         exp_beats;
    int         exp_lat;
  } vec_t;

  logic       clock, resetn, start;
  logic [7:0] start_addr, end_addr;
  logic       busy, done;
  logic [7:0] ram_address, ram_data, ram_q;
  logic       ram_wren;
  logic       out_valid, out_ready;
  logic [7:0] out_data, out_addr;

  logic [7:0] mem [256];
  beat_t      sb [$];
  int         checks, errors, beats_seen, done_cnt;
  logic       prev_stall;
  logic [7:0] prev_a, prev_d;

  mem_stream_reader dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .busy        (busy),
    .done        (done),
    .ram_address (ram_address),
    .ram_wren    (ram_wren),
    .ram_data    (ram_data),
    .ram_q       (ram_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) ram_q <= mem[ram_address];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard, hold-while-stalled and outstanding-read bound monitor.
  always @(negedge clock) begin
    beat_t exp;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_addr", out_addr, prev_a);
        chk("hold_data", out_data, prev_d);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat actual=%0h/%0h required=none", out_addr, out_data);
        end else begin
          exp = sb.pop_front();
          chk("beat_addr", out_addr, exp.a);
          chk("beat_data", out_data, exp.d);
        end
        beats_seen++;
      end
      if (busy) chk("outstanding_le_2", (32'(dut.occ) + 32'(dut.inflight_q)) <= 32'd2, 1);
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_a     = out_addr;
      prev_d     = out_data;
    end
  end

  task automatic push_expected(input logic [7:0] s, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = s + 8'(i);
      sb.push_back('{a: a, d: mem[a]});
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int k, lat, first_v, d0, b0, stall_left;
    bit got;
    d0 = done_cnt;
    b0 = beats_seen;
    @(posedge clock); #1;
    start_addr = v.s;
    end_addr   = v.e;
    start      = 1'b1;
    out_ready  = 1'b1;
    push_expected(v.s, v.exp_beats);
    @(posedge clock); #1;
    start = 1'b0;
    k = 0; got = 0; first_v = -1; lat = -1; stall_left = 0;
    while (!got && k < 2000) begin
      @(negedge clock);
      if (k == 0) chk("busy_after_start", busy, 1);
      if (out_valid && first_v < 0) first_v = k;
      if (done) begin
        got = 1;
        lat = k;
        chk("busy_low_in_done", busy, 0);
      end
      @(posedge clock); #1;
      if (v.poke != 0 && k == 2) begin
        start      = 1'b1;
        start_addr = 8'h90;
        end_addr   = 8'h99;
      end else begin
        start = 1'b0;
      end
      if (v.mode == 0 || got) begin
        out_ready = 1'b1;
      end else begin
        if (k == 3 || $urandom_range(0, 15) == 0) stall_left = 5;
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
      k++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done range=%0h..%0h", v.s, v.e);
    end
    @(negedge clock);
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    if (v.exp_lat >= 0) begin
      chk("done_latency", lat, v.exp_lat);
      chk("first_valid_latency", first_v, 2);
    end
    chk("beat_count", beats_seen - b0, v.exp_beats);
    chk("scoreboard_empty", sb.size(), 0);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    vec_t vecs[7];
    int   k, b0, d0;
    vecs[0] = '{8'h10, 8'h14, 0, 0, 5,   7};
    vecs[1] = '{8'h80, 8'h80, 0, 0, 1,   3};
    vecs[2] = '{8'hFE, 8'h01, 0, 0, 4,   6};
    vecs[3] = '{8'h00, 8'hFF, 0, 0, 256, 258};
    vecs[4] = '{8'h00, 8'h07, 1, 0, 8,   -1};
    vecs[5] = '{8'h40, 8'h44, 0, 1, 5,   7};
    vecs[6] = '{8'h30, 8'h3F, 1, 0, 16,  -1};

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
    for (int i = 8'h10; i <= 8'h14; i++) mem[i] = 8'(i + 3);
    mem[8'h80] = 8'hA5;

    checks = 0; errors = 0; beats_seen = 0; done_cnt = 0; prev_stall = 1'b0;
    resetn = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("ram_wren_zero", ram_wren, 0);
    chk("ram_data_zero", ram_data, 0);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

    // Reset in the middle of a transfer after a few beats.
    b0 = beats_seen;
    @(posedge clock); #1;
    start_addr = 8'h20; end_addr = 8'h2F; start = 1'b1; out_ready = 1'b1;
    push_expected(8'h20, 16);
    @(posedge clock); #1;
    start = 1'b0;
    k = 0;
    while (beats_seen - b0 < 3 && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (beats_seen - b0 < 3) begin
      checks++;
      errors++;
      $display("FAIL midreset_wait actual=%0d required=3 beats", beats_seen - b0);
    end
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    d0 = done_cnt;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_ram_address", ram_address, 0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (4) @(negedge clock);
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("idle_after_reset", out_valid, 0);

    run_xfer('{8'h50, 8'h53, 0, 0, 4, 6});
    chk("ram_wren_end", ram_wren, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Read-side initiator for the 8-bit single-port synchronous RAM.
- The RAM port is: address, clock, data, wren, q valid one cycle after the address edge.
- On a start pulse, walks an inclusive address range, issuing one read per cycle when possible.
- Returns each word with its address on a valid/ready stream; a 2-entry buffer absorbs RAM read latency under backpressure.
- Feeds downstream consumers such as the decimal display path or a checksum unit, replacing manual switch-driven readout.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM word width.
- BUF_DEPTH, 2, output buffer entries; must be at least RAM latency + 1.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- start_addr  in  ADDR_W  first address; captured on accepted start.
- end_addr  in  ADDR_W  last address, inclusive; captured on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- ram_address  out  ADDR_W  address to RAM.
- ram_wren  out  1  constant 0; reader never writes.
- ram_data  out  DATA_W  constant 0.
- ram_q  in  DATA_W  RAM read data, valid the cycle after the address was issued.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_data  out  DATA_W  word read.
- out_addr  out  ADDR_W  address of out_data.

Behaviour:
- Reset (async, resetn=0): state=IDLE; busy=0, done=0, out_valid=0, ram_address=0; buffer emptied; in-flight read discarded; counters cleared. Reset mid-transfer aborts with no done pulse.
- Length: len = ((end_addr - start_addr) mod 2^ADDR_W) + 1, range 1..256, held in an ADDR_W+1 counter.
  - end < start wraps through 255->0; e.g. start=0xFE, end=0x01 reads FE, FF, 00, 01.
  - start==end reads exactly one word.
- States:
  - IDLE: busy=0. On start=1: latch range, issue_cnt=len, go to RUN.
  - RUN: busy=1. Issue a read in any cycle where issue_cnt>0 and (buffer occupancy + in-flight) < BUF_DEPTH.
    - Issuing drives ram_address=cur_addr, marks one read in flight, then cur_addr increments mod 2^ADDR_W and issue_cnt decrements.
    - In-flight result: the cycle after issue, ram_q and the tagged address are written into the buffer.
    - When issue_cnt==0, in-flight==0, the buffer is empty and the last beat is accepted, go to DONE.
  - DONE: done=1 for exactly one cycle; busy=0 in the same cycle. Go to IDLE.
- Throughput: with out_ready held high, one beat per cycle after a 2-cycle initial latency (start edge -> first issue edge -> q captured -> out_valid). A len-N transfer asserts done N+2 cycles after the start edge.
- Backpressure:
  - out_valid/out_data/out_addr hold stable while out_valid=1 and out_ready=0.
  - No beat is dropped or duplicated.
  - Issue stalls when the buffer plus in-flight count reaches BUF_DEPTH.
- Simultaneous buffer write and pop in one cycle are both honored; occupancy is unchanged.
- start while busy is ignored; start in the DONE cycle is ignored.
- ram_address holds its last value when no read is issued. Reads are side-effect free, so re-presenting an address is harmless.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, state encoding constants (IDLE, RUN, DONE), and a length-compute function (wrap-aware, ADDR_W+1 result).
- Sub-module: stream_fifo2, a 2-entry {addr,data} buffer with valid/ready, push, occupancy output and async active-low reset. Reusable by other RAM-facing blocks.

Test Plan:
1. Preload RAM[i]=i+3 for 0x10..0x14; start 0x10..0x14 with out_ready=1. Expect beats (0x10,0x13)..(0x14,0x17) on consecutive cycles, first out_valid 2 cycles after start, done 7 cycles after start, busy low afterwards.
2. start=end=0x80 with RAM[0x80]=0xA5. Expect exactly one beat (0x80,0xA5), then done.
3. Wrap: start=0xFE, end=0x01. Expect addresses FE, FF, 00, 01 in order; full range 0x00..0xFF yields 256 beats then done.
4. Backpressure: range 0x00..0x07 with out_ready toggled in a pseudo-random pattern, including 5-cycle stalls. Expect all 8 beats in order with no drops or duplicates, outputs stable while stalled, and occupancy + in-flight never above 2.
5. Assert start again during busy. Expect it ignored: range unchanged, single done.
6. Assert resetn=0 mid-transfer after 3 beats. Expect immediate out_valid=0, busy=0, no done. A new start then completes normally.
